// File: rtl/a2p_wb_pkg.sv
// Shared types and constants for the A2P instruction/data Wishbone arbiter.
package a2p_wb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_e;

    localparam logic [2:0] CLASSIC = 3'b000;
    localparam logic [2:0] INCR    = 3'b010;
    localparam logic [2:0] EOB     = 3'b111;

    localparam logic [1:0] LINEAR  = 2'b00;

    // Round-robin pick: on a tie the master that did not win last time gets the bus.
    function automatic grant_e rr_pick(input logic req_i, input logic req_d, input grant_e last);
        if (req_i && req_d) begin
            return (last == GNT_I) ? GNT_D : GNT_I;
        end else if (req_i) begin
            return GNT_I;
        end else if (req_d) begin
            return GNT_D;
        end
        return GNT_NONE;
    endfunction

endpackage

// File: rtl/a2p_wb_timeout.sv
// Bus watchdog: counts strobe cycles without a slave response and fires a one-cycle expire.
module a2p_wb_timeout #(
    parameter int CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic stb,
    input  logic ack,
    input  logic err,
    input  logic clr,
    output logic expire
);

    localparam int CNT_W = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // A slave response in the expiry cycle wins, so ack/err suppress the synthetic error.
    assign expire = stb && !ack && !err && !clr && (cnt_reg == LAST);

    always_comb begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (clr || !stb || ack || err || expire) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/a2p_wb_arbiter.sv
// Round-robin arbiter merging the A2P instruction and data Wishbone masters onto one slave port.
module a2p_wb_arbiter
    import a2p_wb_pkg::*;
#(
    parameter int ADR_W          = 30,
    parameter int DAT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               wb_i_CYC,
    input  logic               wb_i_STB,
    input  logic [ADR_W-1:0]   wb_i_ADR,
    input  logic [1:0]         wb_i_BTE,
    input  logic [2:0]         wb_i_CTI,
    output logic               wb_i_ACK,
    output logic               wb_i_ERR,
    output logic [DAT_W-1:0]   wb_i_DAT_MISO,

    input  logic               wb_d_CYC,
    input  logic               wb_d_STB,
    input  logic               wb_d_WE,
    input  logic [ADR_W-1:0]   wb_d_ADR,
    input  logic [DAT_W-1:0]   wb_d_DAT_MOSI,
    input  logic [DAT_W/8-1:0] wb_d_SEL,
    input  logic [1:0]         wb_d_BTE,
    input  logic [2:0]         wb_d_CTI,
    output logic               wb_d_ACK,
    output logic               wb_d_ERR,
    output logic [DAT_W-1:0]   wb_d_DAT_MISO,

    output logic               wb_CYC,
    output logic               wb_STB,
    output logic               wb_WE,
    output logic [ADR_W-1:0]   wb_ADR,
    output logic [DAT_W-1:0]   wb_DAT_MOSI,
    output logic [DAT_W/8-1:0] wb_SEL,
    output logic [1:0]         wb_BTE,
    output logic [2:0]         wb_CTI,
    input  logic               wb_ACK,
    input  logic               wb_ERR,
    input  logic [DAT_W-1:0]   wb_DAT_MISO
);

    grant_e state_reg;
    grant_e state_next;
    grant_e last_reg;
    grant_e last_next;

    logic own_i;
    logic own_d;
    logic own_stb;
    logic expire;

    // Grant is held until the owner drops CYC, so bursts are never split.
    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        case (state_reg)
            GNT_NONE: begin
                state_next = rr_pick(wb_i_CYC, wb_d_CYC, last_reg);
                if (state_next != GNT_NONE) begin
                    last_next = state_next;
                end
            end
            GNT_I: begin
                if (!wb_i_CYC) begin
                    state_next = GNT_NONE;
                end
            end
            GNT_D: begin
                if (!wb_d_CYC) begin
                    state_next = GNT_NONE;
                end
            end
            default: state_next = GNT_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= GNT_NONE;
            last_reg  <= GNT_I;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
        end
    end

    assign own_i   = !reset && (state_reg == GNT_I);
    assign own_d   = !reset && (state_reg == GNT_D);
    assign own_stb = (own_i && wb_i_STB) || (own_d && wb_d_STB);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            a2p_wb_timeout #(
                .CYCLES (TIMEOUT_CYCLES)
            ) u_wdog (
                .clk    (clk),
                .reset  (reset),
                .stb    (own_stb),
                .ack    (wb_ACK),
                .err    (wb_ERR),
                .clr    (!(own_i || own_d)),
                .expire (expire)
            );
        end else begin : g_no_wdog
            assign expire = 1'b0;
        end
    endgenerate

    // Everything idles at zero unless a master owns the bus.
    always_comb begin
        wb_CYC        = 1'b0;
        wb_STB        = 1'b0;
        wb_WE         = 1'b0;
        wb_ADR        = '0;
        wb_DAT_MOSI   = '0;
        wb_SEL        = '0;
        wb_BTE        = '0;
        wb_CTI        = '0;
        wb_i_ACK      = 1'b0;
        wb_i_ERR      = 1'b0;
        wb_d_ACK      = 1'b0;
        wb_d_ERR      = 1'b0;
        wb_i_DAT_MISO = '0;
        wb_d_DAT_MISO = '0;
        if (own_i) begin
            wb_CYC   = wb_i_CYC;
            wb_STB   = wb_i_STB && !expire;
            wb_ADR   = wb_i_ADR;
            wb_SEL   = '1;
            wb_BTE   = wb_i_BTE;
            wb_CTI   = wb_i_CTI;
            wb_i_ACK = wb_ACK;
            wb_i_ERR = wb_ERR || expire;
        end else if (own_d) begin
            wb_CYC      = wb_d_CYC;
            wb_STB      = wb_d_STB && !expire;
            wb_WE       = wb_d_WE;
            wb_ADR      = wb_d_ADR;
            wb_DAT_MOSI = wb_d_DAT_MOSI;
            wb_SEL      = wb_d_SEL;
            wb_BTE      = wb_d_BTE;
            wb_CTI      = wb_d_CTI;
            wb_d_ACK    = wb_ACK;
            wb_d_ERR    = wb_ERR || expire;
        end
        if (own_i || own_d) begin
            wb_i_DAT_MISO = wb_DAT_MISO;
            wb_d_DAT_MISO = wb_DAT_MISO;
        end
    end

endmodule

// File: tb/tb_a2p_wb_arbiter.sv
// Randomised and directed bench for a2p_wb_arbiter against a transaction-level reference model.
module tb_a2p_wb_arbiter;
    import a2p_wb_pkg::*;

    localparam int ADR_W = 30;
    localparam int DAT_W = 32;
    localparam int TO    = 8;

    logic clk = 1'b0;
    logic reset;

    logic              wb_i_CYC, wb_i_STB, wb_i_ACK, wb_i_ERR;
    logic [ADR_W-1:0]  wb_i_ADR;
    logic [1:0]        wb_i_BTE;
    logic [2:0]        wb_i_CTI;
    logic [DAT_W-1:0]  wb_i_DAT_MISO;
    logic              wb_d_CYC, wb_d_STB, wb_d_WE, wb_d_ACK, wb_d_ERR;
    logic [ADR_W-1:0]  wb_d_ADR;
    logic [DAT_W-1:0]  wb_d_DAT_MOSI, wb_d_DAT_MISO;
    logic [3:0]        wb_d_SEL;
    logic [1:0]        wb_d_BTE;
    logic [2:0]        wb_d_CTI;
    logic              wb_CYC, wb_STB, wb_WE, wb_ACK, wb_ERR;
    logic [ADR_W-1:0]  wb_ADR;
    logic [DAT_W-1:0]  wb_DAT_MOSI, wb_DAT_MISO;
    logic [3:0]        wb_SEL;
    logic [1:0]        wb_BTE;
    logic [2:0]        wb_CTI;

    a2p_wb_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .wb_i_CYC(wb_i_CYC), .wb_i_STB(wb_i_STB), .wb_i_ADR(wb_i_ADR), .wb_i_BTE(wb_i_BTE),
        .wb_i_CTI(wb_i_CTI), .wb_i_ACK(wb_i_ACK), .wb_i_ERR(wb_i_ERR), .wb_i_DAT_MISO(wb_i_DAT_MISO),
        .wb_d_CYC(wb_d_CYC), .wb_d_STB(wb_d_STB), .wb_d_WE(wb_d_WE), .wb_d_ADR(wb_d_ADR),
        .wb_d_DAT_MOSI(wb_d_DAT_MOSI), .wb_d_SEL(wb_d_SEL), .wb_d_BTE(wb_d_BTE), .wb_d_CTI(wb_d_CTI),
        .wb_d_ACK(wb_d_ACK), .wb_d_ERR(wb_d_ERR), .wb_d_DAT_MISO(wb_d_DAT_MISO),
        .wb_CYC(wb_CYC), .wb_STB(wb_STB), .wb_WE(wb_WE), .wb_ADR(wb_ADR), .wb_DAT_MOSI(wb_DAT_MOSI),
        .wb_SEL(wb_SEL), .wb_BTE(wb_BTE), .wb_CTI(wb_CTI), .wb_ACK(wb_ACK), .wb_ERR(wb_ERR),
        .wb_DAT_MISO(wb_DAT_MISO)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_no   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc_no, got, exp);
        end
    endtask

    // Reference model: owner (0 none, 1 I, 2 D), last winner, unanswered-strobe run length.
    int   m_own, m_last, m_wd;
    logic m_ostb, m_to;
    logic e_cyc, e_stb, e_we, e_iack, e_ierr, e_dack, e_derr;
    logic [ADR_W-1:0] e_adr;
    logic [DAT_W-1:0] e_mosi, e_idat, e_ddat;
    logic [3:0] e_sel;
    logic [1:0] e_bte;
    logic [2:0] e_cti;

    task automatic model_comb();
        e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_mosi = '0; e_sel = '0; e_bte = '0; e_cti = '0;
        e_iack = 0; e_ierr = 0; e_dack = 0; e_derr = 0; e_idat = '0; e_ddat = '0;
        m_ostb = 0; m_to = 0;
        if (!reset && m_own != 0) begin
            if (m_own == 1) begin
                e_cyc = wb_i_CYC; m_ostb = wb_i_STB; e_adr = wb_i_ADR;
                e_bte = wb_i_BTE; e_cti = wb_i_CTI; e_sel = 4'hF;
            end else begin
                e_cyc = wb_d_CYC; m_ostb = wb_d_STB; e_adr = wb_d_ADR; e_we = wb_d_WE;
                e_mosi = wb_d_DAT_MOSI; e_sel = wb_d_SEL; e_bte = wb_d_BTE; e_cti = wb_d_CTI;
            end
            // The TO-th consecutive unanswered strobe cycle becomes a synthetic error.
            m_to  = (m_ostb && !wb_ACK && !wb_ERR && (m_wd + 1 == TO));
            e_stb = m_ostb && !m_to;
            if (m_own == 1) begin
                e_iack = wb_ACK; e_ierr = wb_ERR || m_to;
            end else begin
                e_dack = wb_ACK; e_derr = wb_ERR || m_to;
            end
            e_idat = wb_DAT_MISO; e_ddat = wb_DAT_MISO;
        end
    endtask

    task automatic settle();
        #3;
        model_comb();
        check("wb_CYC",   64'(wb_CYC),        64'(e_cyc));
        check("wb_STB",   64'(wb_STB),        64'(e_stb));
        check("wb_WE",    64'(wb_WE),         64'(e_we));
        check("wb_ADR",   64'(wb_ADR),        64'(e_adr));
        check("wb_MOSI",  64'(wb_DAT_MOSI),   64'(e_mosi));
        check("wb_SEL",   64'(wb_SEL),        64'(e_sel));
        check("wb_BTE",   64'(wb_BTE),        64'(e_bte));
        check("wb_CTI",   64'(wb_CTI),        64'(e_cti));
        check("i_ACK",    64'(wb_i_ACK),      64'(e_iack));
        check("i_ERR",    64'(wb_i_ERR),      64'(e_ierr));
        check("d_ACK",    64'(wb_d_ACK),      64'(e_dack));
        check("d_ERR",    64'(wb_d_ERR),      64'(e_derr));
        check("i_MISO",   64'(wb_i_DAT_MISO), 64'(e_idat));
        check("d_MISO",   64'(wb_d_DAT_MISO), 64'(e_ddat));
    endtask

    task automatic tick();
        int n_own, n_last, n_wd;
        logic ocyc;
        n_own = m_own; n_last = m_last; n_wd = m_wd;
        if (reset) begin
            n_own = 0; n_last = 1; n_wd = 0;
        end else if (m_own == 0) begin
            n_wd = 0;
            if (wb_i_CYC && wb_d_CYC) n_own = (m_last == 1) ? 2 : 1;
            else if (wb_i_CYC)        n_own = 1;
            else if (wb_d_CYC)        n_own = 2;
            if (n_own != 0) n_last = n_own;
        end else begin
            ocyc = (m_own == 1) ? wb_i_CYC : wb_d_CYC;
            if (!ocyc) begin
                n_own = 0; n_wd = 0;
            end else begin
                n_wd = (m_ostb && !wb_ACK && !wb_ERR && !m_to) ? m_wd + 1 : 0;
            end
        end
        @(posedge clk);
        m_own = n_own; m_last = n_last; m_wd = n_wd;
        #1;
        cyc_no++;
    endtask

    task automatic bus_zero();
        wb_i_CYC = 0; wb_i_STB = 0; wb_i_ADR = '0; wb_i_BTE = LINEAR; wb_i_CTI = CLASSIC;
        wb_d_CYC = 0; wb_d_STB = 0; wb_d_WE = 0; wb_d_ADR = '0; wb_d_DAT_MOSI = '0;
        wb_d_SEL = 4'hF; wb_d_BTE = LINEAR; wb_d_CTI = CLASSIC;
        wb_ACK = 0; wb_ERR = 0; wb_DAT_MISO = '0;
    endtask

    task automatic idle_cycles(input int n);
        bus_zero();
        for (int k = 0; k < n; k++) begin
            settle(); tick();
        end
    endtask

    // Random master state, index 0 = instruction, 1 = data.
    int   act[2], beats[2], total[2], gap[2];
    logic [ADR_W-1:0] madr[2];
    logic mwe[2];
    logic p_ack[2], p_err[2], p_stb[2];
    int   resp_pct;

    task automatic drive_masters();
        logic stb;
        logic [2:0] cti;
        for (int m = 0; m < 2; m++) begin
            if (act[m] != 0 && p_stb[m] && (p_ack[m] || p_err[m])) begin
                beats[m]--; madr[m]++;
                if (beats[m] == 0 || p_err[m]) begin
                    act[m] = 0; gap[m] = $urandom_range(1, 3);
                end
            end else if (act[m] == 0) begin
                if (gap[m] > 0) gap[m]--;
                else if ($urandom_range(0, 99) < 40) begin
                    act[m] = 1; total[m] = $urandom_range(1, 4); beats[m] = total[m];
                    madr[m] = ADR_W'($urandom); mwe[m] = 1'($urandom_range(0, 1));
                end
            end
            stb = (act[m] != 0) && ($urandom_range(0, 9) != 0);
            cti = (total[m] == 1) ? CLASSIC : ((beats[m] == 1) ? EOB : INCR);
            if (m == 0) begin
                wb_i_CYC = (act[0] != 0); wb_i_STB = stb; wb_i_ADR = madr[0];
                wb_i_CTI = cti; wb_i_BTE = 2'($urandom);
            end else begin
                wb_d_CYC = (act[1] != 0); wb_d_STB = stb; wb_d_ADR = madr[1]; wb_d_WE = mwe[1];
                wb_d_CTI = cti; wb_d_BTE = 2'($urandom);
                wb_d_DAT_MOSI = $urandom; wb_d_SEL = 4'($urandom);
            end
        end
    endtask

    initial begin
        int ord[4];
        int got_n;
        logic di, dd;
        int r;

        m_own = 0; m_last = 1; m_wd = 0;
        reset = 1;
        idle_cycles(2);
        check("rst_cyc", 64'(wb_CYC), 64'(0));
        reset = 0;
        idle_cycles(1);

        // Single instruction read.
        wb_i_CYC = 1; wb_i_STB = 1; wb_i_ADR = 30'h100;
        settle(); check("t0_cyc", 64'(wb_CYC), 64'(0)); tick();
        settle();
        check("t1_cyc", 64'(wb_CYC), 64'(1)); check("t1_adr", 64'(wb_ADR), 64'h100);
        check("t1_we", 64'(wb_WE), 64'(0));   check("t1_sel", 64'(wb_SEL), 64'hF);
        tick();
        wb_ACK = 1; wb_DAT_MISO = 32'hDEADBEEF;
        settle();
        check("t2_iack", 64'(wb_i_ACK), 64'(1)); check("t2_idat", 64'(wb_i_DAT_MISO), 64'hDEADBEEF);
        check("t2_dack", 64'(wb_d_ACK), 64'(0));
        tick();
        idle_cycles(2);

        // Tie straight after reset goes to D; one bubble before I.
        reset = 1; idle_cycles(1); reset = 0;
        wb_i_CYC = 1; wb_i_STB = 1; wb_i_ADR = 30'h11;
        wb_d_CYC = 1; wb_d_STB = 1; wb_d_ADR = 30'h22;
        settle(); tick();
        wb_ACK = 1;
        settle();
        check("tie_adr", 64'(wb_ADR), 64'h22); check("tie_iack", 64'(wb_i_ACK), 64'(0));
        tick();
        wb_ACK = 0; wb_d_CYC = 0; wb_d_STB = 0;
        settle(); tick();
        settle(); check("tie_bubble", 64'(wb_CYC), 64'(0)); tick();
        wb_ACK = 1;
        settle(); check("tie_i_adr", 64'(wb_ADR), 64'h11); check("tie_i_ack", 64'(wb_i_ACK), 64'(1));
        tick();
        idle_cycles(2);

        // Round-robin with both masters re-requesting after every transfer.
        wb_i_ADR = 30'h1; wb_d_ADR = 30'h2;
        got_n = 0; di = 0; dd = 0;
        for (int c = 0; c < 40 && got_n < 4; c++) begin
            wb_i_CYC = !di; wb_i_STB = !di; wb_d_CYC = !dd; wb_d_STB = !dd;
            model_comb();
            wb_ACK = m_ostb;
            settle();
            if (wb_i_ACK) begin ord[got_n] = 1; got_n++; end
            else if (wb_d_ACK) begin ord[got_n] = 2; got_n++; end
            di = e_iack; dd = e_dack;
            tick();
        end
        check("rr_count", 64'(got_n), 64'(4));
        for (int k = 0; k < 4 && k < got_n; k++) check("rr_order", 64'(ord[k]), 64'((k % 2 == 0) ? 2 : 1));
        idle_cycles(2);

        // D burst holds the grant while I waits.
        wb_i_CYC = 1; wb_i_STB = 1; wb_i_ADR = 30'h80;
        wb_d_CYC = 1; wb_d_STB = 1; wb_d_ADR = 30'h40; wb_d_CTI = INCR;
        settle(); tick();
        for (int b = 0; b < 4; b++) begin
            wb_d_ADR = 30'h40 + ADR_W'(b); wb_d_CTI = (b == 3) ? EOB : INCR; wb_ACK = 1;
            settle();
            check("burst_cti", 64'(wb_CTI), 64'((b == 3) ? EOB : INCR));
            check("burst_adr", 64'(wb_ADR), 64'(30'h40 + ADR_W'(b)));
            check("burst_dack", 64'(wb_d_ACK), 64'(1)); check("burst_iack", 64'(wb_i_ACK), 64'(0));
            tick();
        end
        wb_ACK = 0; wb_d_CYC = 0; wb_d_STB = 0;
        settle(); tick();
        settle(); check("burst_bubble", 64'(wb_CYC), 64'(0)); tick();
        settle(); check("burst_i_adr", 64'(wb_ADR), 64'h80); tick();
        idle_cycles(2);

        // Watchdog: silent slave, then a slave ACK landing on the expiry cycle.
        wb_d_CYC = 1; wb_d_STB = 1; wb_d_ADR = 30'h55;
        settle(); tick();
        for (int n = 1; n <= 9; n++) begin
            settle();
            check("to_derr", 64'(wb_d_ERR), 64'(n == 8));
            check("to_stb", 64'(wb_STB), 64'(n != 8));
            tick();
        end
        idle_cycles(2);
        wb_d_CYC = 1; wb_d_STB = 1;
        settle(); tick();
        for (int n = 1; n <= 8; n++) begin
            wb_ACK = (n == 8);
            settle();
            if (n == 8) begin
                check("to_ack_wins", 64'(wb_d_ACK), 64'(1));
                check("to_no_err", 64'(wb_d_ERR), 64'(0));
                check("to_ack_stb", 64'(wb_STB), 64'(1));
            end
            tick();
        end
        idle_cycles(2);

        // Reset during beat 2 of an I burst; pending D wins afterwards.
        wb_i_CYC = 1; wb_i_STB = 1; wb_i_ADR = 30'h200; wb_i_CTI = INCR;
        settle(); tick();
        wb_ACK = 1;
        settle(); check("rb_beat1", 64'(wb_i_ACK), 64'(1)); tick();
        wb_i_ADR = 30'h201; reset = 1;
        wb_d_CYC = 1; wb_d_STB = 1; wb_d_ADR = 30'h300;
        settle(); tick();
        reset = 0;
        settle();
        check("rb_cyc", 64'(wb_CYC), 64'(0)); check("rb_stb", 64'(wb_STB), 64'(0));
        check("rb_iack", 64'(wb_i_ACK), 64'(0)); check("rb_adr", 64'(wb_ADR), 64'(0));
        tick();
        settle(); check("rb_d_first", 64'(wb_ADR), 64'h300); check("rb_d_ack", 64'(wb_d_ACK), 64'(1));
        tick();
        idle_cycles(2);

        // Random traffic with varying slave responsiveness and occasional resets.
        for (int m = 0; m < 2; m++) begin
            act[m] = 0; beats[m] = 0; total[m] = 1; gap[m] = 0; madr[m] = '0; mwe[m] = 0;
            p_ack[m] = 0; p_err[m] = 0; p_stb[m] = 0;
        end
        resp_pct = 85;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) resp_pct = ((c / 250) % 3 == 0) ? 85 : (((c / 250) % 3 == 1) ? 40 : 6);
            reset = ($urandom_range(0, 399) == 0);
            drive_masters();
            model_comb();
            wb_ACK = 0; wb_ERR = 0;
            if (m_ostb) begin
                r = $urandom_range(0, 99);
                wb_ACK = (r < resp_pct);
                wb_ERR = (r >= resp_pct && r < resp_pct + 4);
                if ($urandom_range(0, 49) == 0) begin wb_ACK = 1; wb_ERR = 1; end
            end
            wb_DAT_MISO = $urandom;
            settle();
            p_ack[0] = e_iack; p_err[0] = e_ierr; p_stb[0] = wb_i_STB;
            p_ack[1] = e_dack; p_err[1] = e_derr; p_stb[1] = wb_d_STB;
            tick();
        end
        reset = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/a2p_wb_arbiter.md
Name: a2p_wb_arbiter

Overview:
Two-master to one-slave Wishbone arbiter that sits directly downstream of the A2P core. It merges the core's instruction bus (wb_i, read-only) and data bus (wb_d) onto a single shared Wishbone master port, wb, which feeds the memory/peripheral fabric. Arbitration is round-robin with a registered grant, and the grant is held for the whole CYC (burst) of the owning master. A bus-timeout watchdog returns ERR to a master whose slave never responds.

Parameters:
ADR_W, 30, word-address width of all three ports.
DAT_W, 32, data width; SEL width is DAT_W/8.
TIMEOUT_CYCLES, 1024, maximum STB-without-ACK/ERR cycles before the arbiter generates ERR; 0 disables the watchdog.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wb_i_CYC, wb_i_STB  in  1  instruction-master cycle/strobe
wb_i_ADR  in  ADR_W  instruction word address
wb_i_BTE  in  2  instruction burst type
wb_i_CTI  in  3  instruction cycle type
wb_i_ACK, wb_i_ERR  out  1  instruction ack/error
wb_i_DAT_MISO  out  DAT_W  instruction read data
wb_d_CYC, wb_d_STB, wb_d_WE  in  1  data-master cycle/strobe/write
wb_d_ADR  in  ADR_W  data word address
wb_d_DAT_MOSI  in  DAT_W  data write data
wb_d_SEL  in  DAT_W/8  data byte selects
wb_d_BTE  in  2  data burst type
wb_d_CTI  in  3  data cycle type
wb_d_ACK, wb_d_ERR  out  1  data ack/error
wb_d_DAT_MISO  out  DAT_W  data read data
wb_CYC, wb_STB, wb_WE  out  1  shared-bus cycle/strobe/write
wb_ADR  out  ADR_W  shared-bus address
wb_DAT_MOSI  out  DAT_W  shared-bus write data
wb_SEL  out  DAT_W/8  shared-bus byte selects
wb_BTE  out  2  shared-bus burst type
wb_CTI  out  3  shared-bus cycle type
wb_ACK, wb_ERR  in  1  shared-bus ack/error from the slave
wb_DAT_MISO  in  DAT_W  shared-bus read data

Behaviour:
- Reset: state=IDLE, last_grant=I, timeout counter=0. All outputs are 0 during reset and whenever the state is IDLE.
- States:
  - IDLE: no grant. Evaluate the CYC inputs:
    - only one master requesting: grant it;
    - both requesting: grant the master that is not last_grant;
    - neither: stay in IDLE.
    - The grant register updates on this edge, so the first shared-bus cycle comes 1 clk after the request appears (1-cycle arbitration latency). last_grant updates whenever a grant is issued.
  - GNT_I / GNT_D: the owner's CYC/STB/ADR/BTE/CTI (plus WE/DAT_MOSI/SEL for D) are combinationally muxed onto wb_*.
    - In GNT_I: wb_WE=0, wb_SEL=all ones, wb_DAT_MOSI=0.
    - wb_ACK/wb_ERR are routed only to the owner; the non-owner's ACK/ERR stay 0.
    - wb_DAT_MISO is broadcast to both masters.
  - Release: when the owner's CYC is sampled low, go to IDLE. This gives one idle bubble before any re-grant, including an immediate hand-off to the other master.
  - The grant is held while CYC is high regardless of CTI/BTE. Bursts and multi-beat cycles are never split.
- Non-owner stall: a master that is waiting sees ACK=0 and ERR=0. Its request persists via CYC.
- Watchdog (TIMEOUT_CYCLES>0):
  - The counter increments each cycle that wb_STB=1 and wb_ACK=wb_ERR=0. It clears on ACK, on ERR, on STB low, and in IDLE.
  - When the count reaches TIMEOUT_CYCLES-1 with still no response, the arbiter drives a one-cycle ERR to the owner, masks wb_STB to 0 for that cycle, and clears the counter.
  - If the slave's ACK or ERR arrives in the same cycle as the timeout, the slave's response wins and no synthetic ERR is generated.
  - wb_ERR from the slave passes through unchanged.
- Simultaneous ACK and ERR from the slave: both are forwarded as-is. The arbiter does not resolve them.
- Reset asserted mid-cycle: all outputs go to 0 on the next edge and the grant is lost. The slave is expected to see CYC drop and abort.
- Width rules:
  - Counter width is clog2(TIMEOUT_CYCLES+1).
  - No address translation; ADR passes through unchanged.

Decomposition:
- Package a2p_wb_pkg holds:
  - grant enum {GNT_NONE, GNT_I, GNT_D};
  - CTI constants CLASSIC=3'b000, INCR=3'b010, EOB=3'b111;
  - BTE constants LINEAR=2'b00.
- One sub-module, a2p_wb_timeout: a parameterised watchdog counter with inputs stb/ack/err/clr and a one-cycle expire output. Instantiate it only when TIMEOUT_CYCLES>0 (generate).

Test Plan:
- Single I read: wb_i CYC/STB, ADR=0x100 at t0; slave ACKs with DAT 0xDEADBEEF at t2 -> wb_CYC rises at t1, wb_ADR=0x100, wb_WE=0, wb_SEL=4'hF; wb_i_ACK=1 with DAT 0xDEADBEEF at t2; wb_d_ACK stays 0.
- Tie after reset: I and D raise CYC in the same cycle -> D granted first (last_grant=I). After D drops CYC: one IDLE cycle, then I granted.
- Round-robin: both masters hold requests continuously for 4 single transfers -> grant order alternates D,I,D,I with one IDLE bubble between owners.
- Burst hold: D 4-beat INCR burst with CTI 010,010,010,111 while I is requesting -> I is not granted until D's CYC drops; all 4 D beats appear contiguously on wb_*.
- Timeout: TIMEOUT_CYCLES=8, D STB high and slave silent -> wb_d_ERR=1 for exactly one cycle, 8 cycles after STB is first seen on wb; wb_STB=0 that cycle. A slave ACK arriving on cycle 8 instead -> ACK is forwarded and no ERR.
- Reset mid-burst: reset asserted during beat 2 of an I burst -> all wb_* and master ACK/ERR outputs are 0 on the next edge; state returns to IDLE, and after reset release a pending D request is granted first.
